fwd_hazard_unit: RTL

Parametrised operand forwarding and hazard-stall unit for the ID/EX boundary of the HeliumCPUv2 pipeline. Selects the youngest valid producer result for each EX source operand across NUM_PROD later stages. Raises a stall when the youngest matching producer has no data ready yet, such as a load still in MEM or a multi-cycle op. Adds sequential stall tracking on top: stall-state FSM, per-episode length counter, watchdog timeout, and saturating performance counters.

---
 rtl/fwd_hazard_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard stall unit for the ID/EX boundary.
// Picks the youngest matching producer per source operand, raises a stall
// when that producer's result is not ready yet, and tracks stall episodes
// (length, watchdog timeout, saturating performance counters).
//
// Handshake note: stall is a combinational "not ready" back to PC/IF/ID.
// While stall = 1 the consumer is held and a bubble enters EX; producers
// whose results are not ready are likewise held, so the episode ends in the
// cycle the matching producer raises prod_ready.
module fwd_hazard_unit #(
  parameter int W         = 32,
  parameter int RAW       = 5,
  parameter int NUM_PROD  = 2,
  parameter int CNT_W     = 32,
  parameter int STALL_MAX = 15,
  localparam int SELW     = $clog2(NUM_PROD + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe_flush,
  input  logic                  stat_clear,
  input  logic                  rs_read,
  input  logic                  rt_read,
  input  logic [RAW-1:0]        rs_addr,
  input  logic [RAW-1:0]        rt_addr,
  input  logic [W-1:0]          rs_val,
  input  logic [W-1:0]          rt_val,
  input  logic [NUM_PROD-1:0]   prod_we,
  input  logic [NUM_PROD*RAW-1:0] prod_addr,
  input  logic [NUM_PROD-1:0]   prod_ready,
  input  logic [NUM_PROD*W-1:0] prod_data,
  output logic [W-1:0]          rs_fwd_val,
  output logic [W-1:0]          rt_fwd_val,
  output logic [SELW-1:0]       rs_fwd_sel,
  output logic [SELW-1:0]       rt_fwd_sel,
  output logic                  stall,
  output logic [7:0]            stall_len,
  output logic                  stall_timeout,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      stall_events,
  output logic [CNT_W-1:0]      fwd_count,
  output logic                  dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_STALL = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_len;
  logic [7:0]       w_len_nxt;
  logic             r_timeout;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_stall_events;
  logic [CNT_W-1:0] r_fwd_count;

  logic             w_rs_blk;
  logic             w_rt_blk;
  logic             w_hazard;
  logic             w_new_event;
  logic [1:0]       w_fwd_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [1:0]       inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // rs operand: scan oldest to youngest so the lowest matching stage wins
  always_comb begin
    rs_fwd_sel = '0;
    rs_fwd_val = rs_val;
    w_rs_blk   = 1'b0;
    for (int k = NUM_PROD - 1; k >= 0; k--) begin
      if (rs_read && prod_we[k] && (rs_addr != '0) &&
          (rs_addr == prod_addr[k*RAW +: RAW])) begin
        rs_fwd_sel = SELW'(k + 1);
        if (prod_ready[k]) begin
          rs_fwd_val = prod_data[k*W +: W];
          w_rs_blk   = 1'b0;
        end else begin
          rs_fwd_val = rs_val;
          w_rs_blk   = 1'b1;
        end
      end
    end
  end

  // rt operand: same selection rule, using rt's own zero-register check
  always_comb begin
    rt_fwd_sel = '0;
    rt_fwd_val = rt_val;
    w_rt_blk   = 1'b0;
    for (int k = NUM_PROD - 1; k >= 0; k--) begin
      if (rt_read && prod_we[k] && (rt_addr != '0) &&
          (rt_addr == prod_addr[k*RAW +: RAW])) begin
        rt_fwd_sel = SELW'(k + 1);
        if (prod_ready[k]) begin
          rt_fwd_val = prod_data[k*W +: W];
          w_rt_blk   = 1'b0;
        end else begin
          rt_fwd_val = rt_val;
          w_rt_blk   = 1'b1;
        end
      end
    end
  end

  // Hazard, episode next-state/length, and per-cycle counter increments
  always_comb begin
    w_hazard    = (w_rs_blk | w_rt_blk) & ~pipe_flush;
    w_state_nxt = S_IDLE;
    w_len_nxt   = 8'd0;
    w_new_event = 1'b0;
    w_fwd_inc   = 2'd0;
    case (r_state)
      S_IDLE: begin
        if (w_hazard) begin
          w_state_nxt = S_STALL;
          w_len_nxt   = 8'd1;
          w_new_event = 1'b1;
        end
      end
      S_STALL: begin
        if (w_hazard) begin
          w_state_nxt = S_STALL;
          w_len_nxt   = (r_len == 8'hFF) ? 8'hFF : r_len + 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (!w_hazard) begin
      w_fwd_inc = {1'b0, (rs_fwd_sel != '0) & ~w_rs_blk} +
                  {1'b0, (rt_fwd_sel != '0) & ~w_rt_blk};
    end
  end

  // Episode state register; stat_clear does not touch it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_len   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
    end
  end

  // Sticky timeout and saturating counters; stat_clear beats increments
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clear) begin
      r_timeout      <= 1'b0;
      r_stall_cycles <= '0;
      r_stall_events <= '0;
      r_fwd_count    <= '0;
    end else begin
      if (w_hazard && (w_len_nxt == 8'(STALL_MAX))) r_timeout <= 1'b1;
      r_stall_cycles <= sat_add(r_stall_cycles, {1'b0, w_hazard});
      r_stall_events <= sat_add(r_stall_events, {1'b0, w_new_event});
      r_fwd_count    <= sat_add(r_fwd_count, w_fwd_inc);
    end
  end

  assign stall         = w_hazard;
  assign stall_len     = r_len;
  assign stall_timeout = r_timeout;
  assign stall_cycles  = r_stall_cycles;
  assign stall_events  = r_stall_events;
  assign fwd_count     = r_fwd_count;
  assign dbg_state     = (r_state == S_STALL);

endmodule
